// File: rtl/soc_ctrl_rst_seq.sv
// soc_ctrl_rst_seq
// Per-domain reset and clock-enable sequencer. After power-on reset, and on
// every software request, it drives the domain through this sequence:
// gate clock, assert reset, release reset, settle, and (software requests
// only) acknowledge.
//
// State table
//   state  | meaning
//   GATE   | domain clock gated, reset still released (GATE_CYCLES)
//   RESET  | domain reset asserted (RST_HOLD_CYCLES); power-on entry state
//   SETTLE | reset released, clock still gated (EN_DELAY_CYCLES)
//   ACK    | software sequence done, waiting for rst_req_i to drop
//   RUN    | normal operation, clk_en_o follows clk_en_req_i
//
// Ports
//   clk_i         sequencer clock
//   arst_ni       asynchronous active-low reset
//   rst_req_i     software reset request (4-phase with rst_ack_o)
//   clk_en_req_i  requested domain clock enable, honoured only in RUN
//   arst_no       domain reset, active-low, registered
//   clk_en_o      domain clock enable, registered
//   rst_ack_o     request acknowledge, registered
//   busy_o        high whenever the sequencer is not in RUN
//   rst_cnt_o     completed software sequences, saturating
//                 (present only with SOC_CTRL_RST_SEQ_CNT_EN defined)
//
// Build option: define SOC_CTRL_RST_SEQ_CNT_EN to add rst_cnt_o.

module soc_ctrl_rst_seq #(
    parameter int unsigned GATE_CYCLES     = 4,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned EN_DELAY_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       arst_ni,
    input  logic       rst_req_i,
    input  logic       clk_en_req_i,
    output logic       arst_no,
    output logic       clk_en_o,
    output logic       rst_ack_o,
    output logic       busy_o
`ifdef SOC_CTRL_RST_SEQ_CNT_EN
    ,
    output logic [7:0] rst_cnt_o
`endif
);

    localparam int unsigned MAX_GR  = (GATE_CYCLES > RST_HOLD_CYCLES) ? GATE_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_GR > EN_DELAY_CYCLES) ? MAX_GR : EN_DELAY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(EN_DELAY_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_GATE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACK    = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sw_q, sw_d;
    logic             arst_d, clk_en_d, ack_d;

    // State register
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_RESET;
            cnt_q   <= RST_LOAD;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
        end
    end

    // Next-state logic; each timed state lasts exactly load+1 cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        case (state_q)
            ST_RUN: begin
                if (rst_req_i) begin
                    state_d = ST_GATE;
                    cnt_d   = GATE_LOAD;
                    sw_d    = 1'b1;
                end
            end
            ST_GATE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESET;
                    cnt_d   = RST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESET: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = sw_q ? ST_ACK : ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (!rst_req_i) begin
                    state_d = ST_RUN;
                    sw_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = RST_LOAD;
            end
        endcase
    end

    // Output decode. The clock enable needs RUN both now and next so that it
    // drops on the request edge and only reopens one cycle after ACK->RUN.
    always_comb begin
        arst_d   = (state_d != ST_RESET);
        ack_d    = (state_d == ST_ACK);
        clk_en_d = (state_q == ST_RUN) && (state_d == ST_RUN) && clk_en_req_i;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            arst_no   <= 1'b0;
            clk_en_o  <= 1'b0;
            rst_ack_o <= 1'b0;
        end else begin
            arst_no   <= arst_d;
            clk_en_o  <= clk_en_d;
            rst_ack_o <= ack_d;
        end
    end

    assign busy_o = (state_q != ST_RUN);

`ifdef SOC_CTRL_RST_SEQ_CNT_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rst_cnt_o <= 8'd0;
        end else if ((state_q == ST_ACK) && (state_d == ST_RUN) && (rst_cnt_o != 8'hFF)) begin
            rst_cnt_o <= rst_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_soc_ctrl_rst_seq.sv
// Directed bench for soc_ctrl_rst_seq with default parameters (G=4, R=16,
// E=8). Inputs change 1 ns after a rising edge; outputs are sampled there too.

module tb_soc_ctrl_rst_seq;

    logic clk_i = 1'b0;
    logic arst_ni;
    logic rst_req_i;
    logic clk_en_req_i;
    logic arst_no;
    logic clk_en_o;
    logic rst_ack_o;
    logic busy_o;
`ifdef SOC_CTRL_RST_SEQ_CNT_EN
    logic [7:0] rst_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    soc_ctrl_rst_seq dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .rst_req_i    (rst_req_i),
        .clk_en_req_i (clk_en_req_i),
        .arst_no      (arst_no),
        .clk_en_o     (clk_en_o),
        .rst_ack_o    (rst_ack_o),
        .busy_o       (busy_o)
`ifdef SOC_CTRL_RST_SEQ_CNT_EN
        ,
        .rst_cnt_o    (rst_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_arst_no"},  {7'd0, arst_no},   8'd0);
        check({tag, "_clk_en"},   {7'd0, clk_en_o},  8'd0);
        check({tag, "_ack"},      {7'd0, rst_ack_o}, 8'd0);
        check({tag, "_busy"},     {7'd0, busy_o},    8'd1);
    endtask

    // Release arst_ni and follow power-on timing for 30 edges.
    // pulse_at != 0 drives rst_req_i high for edges pulse_at and pulse_at+1.
    task automatic power_on(input int pulse_at);
        arst_ni = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (pulse_at != 0 && i == pulse_at)     rst_req_i = 1'b1;
            if (pulse_at != 0 && i == pulse_at + 2) rst_req_i = 1'b0;
            step();
            check($sformatf("por_arst_e%0d", i),   {7'd0, arst_no},   {7'd0, (i >= 16)});
            check($sformatf("por_clken_e%0d", i),  {7'd0, clk_en_o},  {7'd0, (i >= 25)});
            check($sformatf("por_ack_e%0d", i),    {7'd0, rst_ack_o}, 8'd0);
            check($sformatf("por_busy_e%0d", i),   {7'd0, busy_o},    {7'd0, (i < 24)});
        end
    endtask

    initial begin
        logic prev_en;
        arst_ni      = 1'b0;
        rst_req_i    = 1'b0;
        clk_en_req_i = 1'b1;

        // Reset held: reset values
        step();
        step();
        check_reset_vals("rst");

        // Power-on sequence
        power_on(0);

        // clk_en_req_i toggling in RUN: one-cycle lag
        prev_en = clk_en_req_i;
        for (int i = 0; i < 16; i++) begin
            clk_en_req_i = ((i % 3) == 1) ? clk_en_req_i : ~clk_en_req_i;
            prev_en = clk_en_req_i;
            step();
            check($sformatf("tog_clken_%0d", i), {7'd0, clk_en_o}, {7'd0, prev_en});
            check($sformatf("tog_busy_%0d", i),  {7'd0, busy_o},   8'd0);
        end
        clk_en_req_i = 1'b1;
        step();

        // Software reset: edge k is j=0
        rst_req_i = 1'b1;
        for (int j = 0; j <= 28; j++) begin
            step();
            check($sformatf("sw_clken_%0d", j), {7'd0, clk_en_o},  8'd0);
            check($sformatf("sw_arst_%0d", j),  {7'd0, arst_no},   {7'd0, !(j >= 4 && j < 20)});
            check($sformatf("sw_ack_%0d", j),   {7'd0, rst_ack_o}, {7'd0, (j >= 28)});
            check($sformatf("sw_busy_%0d", j),  {7'd0, busy_o},    8'd1);
        end

        // Request held high long after ack: no retrigger
        for (int j = 0; j < 100; j++) begin
            step();
            check($sformatf("hold_ack_%0d", j),  {7'd0, rst_ack_o}, 8'd1);
            check($sformatf("hold_arst_%0d", j), {7'd0, arst_no},   8'd1);
            check($sformatf("hold_busy_%0d", j), {7'd0, busy_o},    8'd1);
        end

        // Release request: edge m
        rst_req_i = 1'b0;
        step();
        check("rel_ack",   {7'd0, rst_ack_o}, 8'd0);
        check("rel_busy",  {7'd0, busy_o},    8'd0);
        check("rel_clken", {7'd0, clk_en_o},  8'd0);
        step();
        check("rel_clken_m1", {7'd0, clk_en_o}, 8'd1);
`ifdef SOC_CTRL_RST_SEQ_CNT_EN
        check("cnt_one", rst_cnt_o, 8'd1);
`endif
        for (int j = 0; j < 10; j++) begin
            step();
            check($sformatf("run_busy_%0d", j), {7'd0, busy_o},    8'd0);
            check($sformatf("run_arst_%0d", j), {7'd0, arst_no},   8'd1);
        end

        // arst_ni pulse during RESET of a software sequence
        rst_req_i = 1'b1;
        for (int j = 0; j <= 10; j++) step();
        check("abort_pre_arst", {7'd0, arst_no}, 8'd0);
        arst_ni = 1'b0;
        #1;
        check_reset_vals("abort");
`ifdef SOC_CTRL_RST_SEQ_CNT_EN
        check("abort_cnt", rst_cnt_o, 8'd0);
`endif
        rst_req_i = 1'b0;
        step();
        step();
        check_reset_vals("abort_hold");
        power_on(0);
        for (int j = 0; j < 10; j++) begin
            step();
            check($sformatf("abort_run_ack_%0d", j),  {7'd0, rst_ack_o}, 8'd0);
            check($sformatf("abort_run_busy_%0d", j), {7'd0, busy_o},    8'd0);
        end

        // rst_req_i pulse during SETTLE of power-on: ignored
        arst_ni = 1'b0;
        step();
        check_reset_vals("por2");
        power_on(19);
        for (int j = 0; j < 20; j++) begin
            step();
            check($sformatf("ign_busy_%0d", j),  {7'd0, busy_o},   8'd0);
            check($sformatf("ign_arst_%0d", j),  {7'd0, arst_no},  8'd1);
            check($sformatf("ign_clken_%0d", j), {7'd0, clk_en_o}, 8'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_ctrl_rst_seq.md
# soc_ctrl_rst_seq

Per-domain reset and clock-enable sequencer in the SoC control block. It is the initiator that drives a domain's reset and clock-enable request lines, which downstream clock/reset delay generation then retimes. On a software reset request it runs a fixed sequence: gate clock, assert reset, release reset, settle, acknowledge. It runs the same reset-release sequence automatically after power-on reset.

## Interface
Parameters:
- GATE_CYCLES, default 4: cycles with clock gated before reset asserts (>=1).
- RST_HOLD_CYCLES, default 16: cycles `arst_no` is held low (>=1).
- EN_DELAY_CYCLES, default 8: settle cycles after reset release, before clock re-enable (>=1).

Ports:
- `clk_i`  in  1  sequencer clock. One clock only.
- `arst_ni`  in  1  asynchronous, active-low reset.
- `rst_req_i`  in  1  software reset request. Level-sensitive, 4-phase with `rst_ack_o`.
- `clk_en_req_i`  in  1  requested domain clock enable. Honoured only in RUN.
- `arst_no`  out  1  domain reset, active-low, registered.
- `clk_en_o`  out  1  domain clock enable, registered.
- `rst_ack_o`  out  1  request acknowledge.
- `busy_o`  out  1  high whenever state != RUN.

## Operation
- States: GATE, RESET, SETTLE, ACK, RUN.
- Down-counter rules:
  - The counter has width `$clog2(max(GATE,RST_HOLD,EN_DELAY))+1`.
  - Entering a timed state loads the counter with N-1.
  - The state exits when the counter reads 0, so each timed state occupies exactly N cycles.
- Flag `sw_q`:
  - Set on the RUN->GATE transition.
  - Cleared on ACK->RUN.
  - Reset value 0.
- Transitions:
  - RUN: `rst_req_i`=1 -> GATE.
  - GATE (N=GATE_CYCLES) -> RESET.
  - RESET (N=RST_HOLD_CYCLES) -> SETTLE.
  - SETTLE (N=EN_DELAY_CYCLES) -> ACK if `sw_q`, else RUN.
  - ACK: `rst_req_i`=0 -> RUN.
- Outputs, registered and decoded from the next state:
  - `arst_no`=0 only in RESET.
  - `clk_en_o`=`clk_en_req_i` only while the current state is RUN, otherwise 0.
  - `rst_ack_o`=1 only in ACK.
- Reset values while `arst_ni`=0:
  - state=RESET, counter=RST_HOLD_CYCLES-1, `sw_q`=0.
  - `arst_no`=0, `clk_en_o`=0, `rst_ack_o`=0, `busy_o`=1.
- Boundary conditions:
  - `rst_req_i` rising outside RUN is ignored. It is sampled again once the sequencer reaches RUN.
  - `rst_req_i` held high through ACK does not retrigger. ACK waits for the low level.
  - `arst_ni` asserted mid-sequence aborts immediately to the reset values. Any pending request is then seen again as a fresh level in RUN.
  - `clk_en_req_i` toggling outside RUN has no effect.

## Timing
- Request path: `rst_req_i` sampled 1 at edge k in RUN. Then:
  - `clk_en_o`=0 and `busy_o`=1 after edge k.
  - `arst_no`=0 after edge k+G.
  - `arst_no`=1 after edge k+G+R.
  - `rst_ack_o`=1 after edge k+G+R+E.
- Request release: `rst_req_i` sampled 0 at edge m in ACK. Then:
  - `rst_ack_o`=0 and `busy_o`=0 after edge m.
  - `clk_en_o` follows `clk_en_req_i` from edge m+1.
- Power-on: the first edge after `arst_ni` deasserts is edge 1. Then:
  - `arst_no`=1 after edge R.
  - RUN after edge R+E.
  - `clk_en_o` is valid from edge R+E+1.
- In RUN, `clk_en_o` lags `clk_en_req_i` by 1 cycle.

## Configuration
- Macro `SOC_CTRL_RST_SEQ_CNT_EN`.
- Defined: adds output `rst_cnt_o` [7:0]. It counts completed software sequences (ACK->RUN transitions), saturates at 255, and resets to 0 on `arst_ni`.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
Defaults for all scenarios: G=4, R=16, E=8, 10 ns clock.
- Power-on: release `arst_ni`, `clk_en_req_i`=1 -> `arst_no` rises 16 cycles later, `clk_en_o` rises 25 cycles later, `rst_ack_o` stays 0 throughout.
- Software reset: `rst_req_i`=1 in RUN -> `clk_en_o` falls next cycle; `arst_no` low for exactly 16 cycles starting 4 cycles after `clk_en_o` falls; `rst_ack_o` 8 cycles after `arst_no` rises. Drop `rst_req_i` -> `rst_ack_o`=0 and `clk_en_o`=1 one cycle later.
- Request held high for 100 cycles after ack -> exactly one sequence; with the macro defined, `rst_cnt_o` increments by 1.
- `arst_ni` pulsed low during RESET of a software sequence -> all outputs return to reset values immediately; the power-on timing then repeats; no ack is issued unless `rst_req_i` is still high.
- `rst_req_i` pulsed high for 2 cycles during SETTLE of a power-on sequence -> ignored; RUN is reached and no GATE is entered.
- `clk_en_req_i` toggled every cycle in RUN -> `clk_en_o` equals the input delayed by 1 cycle.
